// File: rtl/volatility_pkg.sv
// Shared types and widths for the rolling-window volatility engine.
//   - state_e    : processing FSM states
//   - chan_t     : per-stock running state {count, wr_ptr, sum, sumsq}
//   - mid_price(): (ask + bid) >> 1 evaluated one bit wider, then truncated
package volatility_pkg;

  localparam int unsigned VolDataW     = 32;
  localparam int unsigned VolNumStocks = 4;
  localparam int unsigned VolMaxWindow = 32;
  localparam int unsigned VolFpWidth   = 64;
  localparam int unsigned VolFracBits  = 32;

  localparam int unsigned STOCK_W = $clog2(VolNumStocks);
  localparam int unsigned PTR_W   = $clog2(VolMaxWindow);
  localparam int unsigned CNT_W   = $clog2(VolMaxWindow) + 1;
  // Sized so that MAX_WINDOW samples of full-scale prices (and squares) never overflow.
  localparam int unsigned SUM_W   = VolDataW + $clog2(VolMaxWindow) + 1;
  localparam int unsigned SQ_W    = 2 * VolDataW + $clog2(VolMaxWindow) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StUpdate,
    StMean,
    StVar,
    StOut
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [SUM_W-1:0] sum;
    logic [SQ_W-1:0]  sumsq;
  } chan_t;

  function automatic logic [VolDataW-1:0] mid_price(input logic [VolDataW-1:0] ask,
                                                    input logic [VolDataW-1:0] bid);
    logic [VolDataW:0] total;
    total = {1'b0, ask} + {1'b0, bid};
    return total[VolDataW:1];
  endfunction

endpackage

// File: rtl/rolling_volatility_mem.sv
// Single-port synchronous price buffer shared by all stock channels.
//   clk_i   : clock
//   we_i    : write enable (write happens at addr_i)
//   addr_i  : {stock, ptr} word address
//   wdata_i : write data
//   rdata_o : registered read of addr_i (1-cycle latency, read-before-write)
// Contents are intentionally not reset.
module rolling_volatility_mem #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 128,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rolling_volatility.sv
// Multi-stock rolling-window volatility engine.
// Each accepted quote walks IDLE -> READ -> UPDATE -> MEAN -> VAR -> OUT and yields the
// windowed variance E[x^2] - E[x]^2 in Q.FRAC_BITS, scaled by the supplied 1/N.
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_stock_id                : channel of the quote / flush
//   i_data_valid, o_ready     : quote handshake (ready only in IDLE, no queueing)
//   i_best_ask, i_best_bid    : top of book
//   i_window_size/recip       : N and 1/N, sampled at accept
//   i_flush                   : clear channel state (IDLE only, beats a quote)
//   o_volatility ... o_data_valid : one-cycle result bundle
//   o_crossed                 : one-cycle pulse when a quote is dropped for ask < bid
module rolling_volatility
  import volatility_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = VolDataW,
  parameter int unsigned NUM_STOCKS   = VolNumStocks,
  parameter int unsigned MAX_WINDOW   = VolMaxWindow,
  parameter int unsigned FP_WORD_SIZE = VolFpWidth,
  parameter int unsigned FRAC_BITS    = VolFracBits
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_stock_id,
  input  logic                            i_data_valid,
  output logic                            o_ready,
  input  logic [DATA_WIDTH-1:0]           i_best_ask,
  input  logic [DATA_WIDTH-1:0]           i_best_bid,
  input  logic [$clog2(MAX_WINDOW):0]     i_window_size,
  input  logic [FP_WORD_SIZE-1:0]         i_window_recip,
  input  logic                            i_flush,
  output logic [FP_WORD_SIZE-1:0]         o_volatility,
  output logic [DATA_WIDTH-1:0]           o_curr_price,
  output logic [$clog2(NUM_STOCKS)-1:0]   o_stock_id,
  output logic                            o_window_full,
  output logic                            o_data_valid,
  output logic                            o_crossed
);

  localparam int unsigned MEAN_W = SUM_W + FP_WORD_SIZE;
  localparam int unsigned EX2_W  = SQ_W + FP_WORD_SIZE;
  localparam int unsigned MSQ_W  = 2 * MEAN_W;
  localparam int unsigned ADDR_W = STOCK_W + PTR_W;

  state_e                   state_q, state_d;
  logic [STOCK_W-1:0]       stock_q, stock_d;
  logic [DATA_WIDTH-1:0]    mid_q, mid_d;
  logic [CNT_W-1:0]         win_q, win_d;
  logic [FP_WORD_SIZE-1:0]  recip_q, recip_d;
  chan_t                    chan_q [NUM_STOCKS];
  chan_t                    chan_d [NUM_STOCKS];
  logic [MEAN_W-1:0]        mean_q, mean_d;
  logic [EX2_W-1:0]         ex2_q, ex2_d;

  logic [FP_WORD_SIZE-1:0]  vol_q, vol_d;
  logic [DATA_WIDTH-1:0]    price_q, price_d;
  logic [STOCK_W-1:0]       oid_q, oid_d;
  logic                     full_q, full_d;
  logic                     valid_q, valid_d;
  logic                     crossed_q, crossed_d;

  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  chan_t                    cur;
  logic [SQ_W-1:0]          mid_sq, old_sq;
  logic                     win_full, ptr_wrap;
  logic [MSQ_W-1:0]         msq, ex2_ext;

  rolling_volatility_mem #(
    .Width (DATA_WIDTH),
    .Depth (NUM_STOCKS * MAX_WINDOW),
    .AddrW (ADDR_W)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mid_q),
    .rdata_o (mem_rdata)
  );

  assign cur      = chan_q[stock_q];
  assign mid_sq   = SQ_W'(mid_q) * SQ_W'(mid_q);
  // mem_rdata holds the evicted sample during UPDATE (read was issued in READ).
  assign old_sq   = SQ_W'(mem_rdata) * SQ_W'(mem_rdata);
  assign win_full = (cur.count == win_q);
  assign ptr_wrap = (CNT_W'(cur.wr_ptr) == win_q - CNT_W'(1));
  assign msq      = (MSQ_W'(mean_q) * MSQ_W'(mean_q)) >> FRAC_BITS;
  assign ex2_ext  = MSQ_W'(ex2_q);
  assign mem_addr = {stock_q, cur.wr_ptr};

  always_comb begin
    state_d   = state_q;
    stock_d   = stock_q;
    mid_d     = mid_q;
    win_d     = win_q;
    recip_d   = recip_q;
    chan_d    = chan_q;
    mean_d    = mean_q;
    ex2_d     = ex2_q;
    vol_d     = vol_q;
    price_d   = price_q;
    oid_d     = oid_q;
    full_d    = full_q;
    valid_d   = 1'b0;
    crossed_d = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_flush) begin
          chan_d[i_stock_id] = '0;
        end else if (i_data_valid) begin
          if (i_best_ask < i_best_bid) begin
            crossed_d = 1'b1;
          end else begin
            stock_d = i_stock_id;
            mid_d   = mid_price(i_best_ask, i_best_bid);
            win_d   = i_window_size;
            recip_d = i_window_recip;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        state_d = StUpdate;
      end
      StUpdate: begin
        if (win_full) begin
          chan_d[stock_q].sum   = cur.sum + SUM_W'(mid_q) - SUM_W'(mem_rdata);
          chan_d[stock_q].sumsq = cur.sumsq + mid_sq - old_sq;
        end else begin
          chan_d[stock_q].sum   = cur.sum + SUM_W'(mid_q);
          chan_d[stock_q].sumsq = cur.sumsq + mid_sq;
          chan_d[stock_q].count = cur.count + CNT_W'(1);
        end
        chan_d[stock_q].wr_ptr = ptr_wrap ? '0 : cur.wr_ptr + PTR_W'(1);
        mem_we  = 1'b1;
        state_d = StMean;
      end
      StMean: begin
        mean_d  = MEAN_W'(cur.sum) * MEAN_W'(recip_q);
        ex2_d   = EX2_W'(cur.sumsq) * EX2_W'(recip_q);
        state_d = StVar;
      end
      StVar: begin
        // Rounding in 1/N can push E[x]^2 above E[x^2]; clamp instead of wrapping.
        vol_d   = (ex2_ext < msq) ? '0 : FP_WORD_SIZE'(ex2_ext - msq);
        price_d = mid_q;
        oid_d   = stock_q;
        full_d  = win_full;
        valid_d = 1'b1;
        state_d = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      stock_q   <= '0;
      mid_q     <= '0;
      win_q     <= '0;
      recip_q   <= '0;
      mean_q    <= '0;
      ex2_q     <= '0;
      vol_q     <= '0;
      price_q   <= '0;
      oid_q     <= '0;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      crossed_q <= 1'b0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        chan_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      stock_q   <= stock_d;
      mid_q     <= mid_d;
      win_q     <= win_d;
      recip_q   <= recip_d;
      mean_q    <= mean_d;
      ex2_q     <= ex2_d;
      vol_q     <= vol_d;
      price_q   <= price_d;
      oid_q     <= oid_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      crossed_q <= crossed_d;
      chan_q    <= chan_d;
    end
  end

  assign o_ready       = (state_q == StIdle);
  assign o_volatility  = vol_q;
  assign o_curr_price  = price_q;
  assign o_stock_id    = oid_q;
  assign o_window_full = full_q;
  assign o_data_valid  = valid_q;
  assign o_crossed     = crossed_q;

endmodule

// File: tb/tb_rolling_volatility.sv
// Bench for rolling_volatility: a sliding-window reference model (explicit sample history
// per stock, variance recomputed from scratch each quote) checked every cycle, plus
// hand-computed literal expectations on directed scenarios.
module tb_rolling_volatility;

  localparam int NS = 4;
  localparam int MW = 32;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [1:0]  i_stock_id = '0;
  logic        i_data_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_best_ask = '0;
  logic [31:0] i_best_bid = '0;
  logic [5:0]  i_window_size = 6'd4;
  logic [63:0] i_window_recip = 64'h4000_0000;
  logic        i_flush = 1'b0;
  logic [63:0] o_volatility;
  logic [31:0] o_curr_price;
  logic [1:0]  o_stock_id;
  logic        o_window_full;
  logic        o_data_valid;
  logic        o_crossed;

  rolling_volatility dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_stock_id     (i_stock_id),
    .i_data_valid   (i_data_valid),
    .o_ready        (o_ready),
    .i_best_ask     (i_best_ask),
    .i_best_bid     (i_best_bid),
    .i_window_size  (i_window_size),
    .i_window_recip (i_window_recip),
    .i_flush        (i_flush),
    .o_volatility   (o_volatility),
    .o_curr_price   (o_curr_price),
    .o_stock_id     (o_stock_id),
    .o_window_full  (o_window_full),
    .o_data_valid   (o_data_valid),
    .o_crossed      (o_crossed)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [63:0] vol;
    logic [31:0] price;
    logic [1:0]  id;
    logic        full;
  } exp_t;

  logic [31:0] hist [NS][MW];
  int          hlen [NS];
  exp_t        exp_q [$];
  int          ready_at = 0;
  int          crossed_at = -1;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Variance of the samples currently in the window, straight from the definition.
  function automatic logic [63:0] model_var(input int s, input logic [63:0] recip);
    logic [255:0] sum, sq, v, r, mean, ex2, msq;
    sum = '0;
    sq  = '0;
    r   = 256'(recip);
    for (int i = 0; i < hlen[s]; i++) begin
      v   = 256'(hist[s][i]);
      sum = sum + v;
      sq  = sq + v * v;
    end
    mean = sum * r;
    ex2  = sq * r;
    msq  = (mean * mean) >> 32;
    if (ex2 < msq) return 64'd0;
    v = ex2 - msq;
    return v[63:0];
  endfunction

  // Applies the effect of the coming clock edge, given the inputs now on the pins.
  task automatic model_edge();
    int          s, n;
    logic [32:0] tot;
    logic [31:0] mid;
    exp_t        e;
    s = int'(i_stock_id);
    n = int'(i_window_size);
    if (!i_reset_n) begin
      for (int k = 0; k < NS; k++) hlen[k] = 0;
      exp_q.delete();
      ready_at   = cyc + 1;
      crossed_at = -1;
    end else if (cyc >= ready_at) begin
      if (i_flush) begin
        hlen[s] = 0;
      end else if (i_data_valid) begin
        if (i_best_ask < i_best_bid) begin
          crossed_at = cyc + 1;
        end else begin
          tot = {1'b0, i_best_ask} + {1'b0, i_best_bid};
          mid = tot[32:1];
          if (hlen[s] == n) begin
            for (int i = 0; i < n - 1; i++) hist[s][i] = hist[s][i+1];
            hist[s][n-1] = mid;
          end else begin
            hist[s][hlen[s]] = mid;
            hlen[s]++;
          end
          e.due   = cyc + 5;
          e.vol   = model_var(s, i_window_recip);
          e.price = mid;
          e.id    = i_stock_id;
          e.full  = (hlen[s] == n);
          exp_q.push_back(e);
          ready_at = cyc + 6;
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  exp_t ce;
  bit   ev;
  always @(negedge i_clk) begin
    if (chk_en) begin
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("data_valid", 64'(o_data_valid), 64'(ev));
      if (ev) begin
        ce = exp_q.pop_front();
        chk("volatility", o_volatility, ce.vol);
        chk("curr_price", 64'(o_curr_price), 64'(ce.price));
        chk("stock_id", 64'(o_stock_id), 64'(ce.id));
        chk("window_full", 64'(o_window_full), 64'(ce.full));
      end
      chk("ready", 64'(o_ready), 64'(cyc >= ready_at));
      chk("crossed", 64'(o_crossed), 64'(cyc == crossed_at));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge i_clk);
    #1;
    model_edge();
    @(posedge i_clk);
    #1;
  endtask

  // Sends one quote from an idle cycle; samples the outputs at accept+5, returns at accept+6.
  task automatic quote(input int s, input logic [31:0] ask, input logic [31:0] bid,
                       output logic [63:0] vol, output logic full, output logic dv,
                       output logic [1:0] id);
    i_stock_id   = 2'(s);
    i_best_ask   = ask;
    i_best_bid   = bid;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    repeat (4) tick();
    vol  = o_volatility;
    full = o_window_full;
    dv   = o_data_valid;
    id   = o_stock_id;
    tick();
  endtask

  task automatic flush(input int s);
    i_stock_id = 2'(s);
    i_flush    = 1'b1;
    tick();
    i_flush    = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    logic        f, dv;
    logic [1:0]  id;
    int          mids [5];
    int          cnt_a, cnt_b;
    int          r, n;
    logic [31:0] base;
    mids = '{100, 102, 98, 100, 104};

    i_reset_n = 1'b0;
    tick();
    tick();
    chk_en    = 1'b1;
    i_reset_n = 1'b1;
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_valid", 64'(o_data_valid), 64'd0);
    chk("reset_vol", o_volatility, 64'd0);

    // Constant mid: window fills on the 4th quote with zero variance.
    for (int k = 0; k < 4; k++) begin
      quote(0, 32'd102, 32'd98, v, f, dv, id);
      chk("s1_strobe", 64'(dv), 64'd1);
      chk("s1_full", 64'(f), 64'(k == 3));
      if (k == 3) chk("s1_vol", v, 64'd0);
    end

    // Variance 2.0 after 4 samples, 5.0 after wrap.
    for (int k = 0; k < 5; k++) begin
      quote(1, 32'(mids[k]), 32'(mids[k]), v, f, dv, id);
      if (k == 3) chk("s2_vol_2p0", v, 64'h2_0000_0000);
      if (k == 4) begin
        chk("s2_vol_5p0", v, 64'h5_0000_0000);
        chk("s2_full", 64'(f), 64'd1);
      end
    end

    // Interleaved channels evolve independently.
    flush(0);
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s <= 2; s += 2) begin
        quote(s, 32'(mids[k]), 32'(mids[k]), v, f, dv, id);
        chk("s3_id", 64'(id), 64'(s));
        if (k == 3) chk("s3_vol_2p0", v, 64'h2_0000_0000);
        if (k == 4) chk("s3_vol_5p0", v, 64'h5_0000_0000);
      end
    end

    // Valid held for 10 cycles: accepts at 0 and 6 only.
    i_stock_id   = 2'd3;
    i_best_ask   = 32'd50;
    i_best_bid   = 32'd50;
    i_data_valid = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 10) i_data_valid = 1'b0;
      if (o_data_valid) cnt_a++;
      if (k <= 5 && !o_ready) cnt_b++;
    end
    chk("hold_accepts", 64'(cnt_a), 64'd2);
    chk("hold_ready_low", 64'(cnt_b), 64'd5);

    // Crossed quote is dropped; window of stock 1 is untouched.
    i_stock_id   = 2'd1;
    i_best_ask   = 32'd90;
    i_best_bid   = 32'd95;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    chk("crossed_pulse", 64'(o_crossed), 64'd1);
    quote(1, 32'd100, 32'd100, v, f, dv, id);
    chk("after_crossed_vol", v, 64'h4_C000_0000);

    // Reset three cycles into a quote aborts it.
    i_stock_id   = 2'd0;
    i_best_ask   = 32'd77;
    i_best_bid   = 32'd77;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    cnt_a = 0;
    repeat (7) begin
      tick();
      if (o_data_valid) cnt_a++;
    end
    chk("reset_abort", 64'(cnt_a), 64'd0);

    // Flush mid-stream restarts warm-up.
    quote(1, 32'd300, 32'd300, v, f, dv, id);
    quote(1, 32'd310, 32'd300, v, f, dv, id);
    flush(1);
    for (int k = 0; k < 4; k++) begin
      quote(1, 32'd100, 32'd100, v, f, dv, id);
      chk("flush_full", 64'(f), 64'(k == 3));
      if (k == 3) chk("flush_vol", v, 64'd0);
    end

    // Randomized phases, each with a fresh window size.
    for (int ph = 0; ph < 4; ph++) begin
      i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      n = $urandom_range(2, 32);
      i_window_size  = 6'(n);
      i_window_recip = (64'd1 << 32) / 64'(n);
      for (int c = 0; c < 700; c++) begin
        r = $urandom_range(0, 99);
        i_stock_id   = 2'($urandom_range(0, 3));
        i_flush      = (r < 3);
        i_data_valid = (r < 60);
        base = (ph == 3) ? 32'($urandom) : 32'($urandom_range(1000, 1200));
        i_best_bid = base;
        i_best_ask = (r >= 55 && r < 60) ? base - 32'd3 : base + 32'($urandom_range(0, 9));
        tick();
      end
      i_flush      = 1'b0;
      i_data_valid = 1'b0;
      repeat (8) tick();
    end

    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rolling_volatility.md
Name: rolling_volatility

Overview:
- Multi-stock rolling-window volatility engine. Successor to the fixed-buffer volatility block.
- For each stock it maintains a circular buffer of mid-prices, plus a running sum and a running sum of squares.
- On each accepted quote it outputs the windowed variance in fixed point, together with the current mid-price.
- Sits between the order-book top-of-book output and the pricing/reference-price stage.

Parameters:
- DATA_WIDTH, 32, price width (unsigned integer ticks).
- NUM_STOCKS, 4, number of independent stock channels.
- MAX_WINDOW, 32, per-stock buffer depth (power of 2).
- FP_WORD_SIZE, 64, fixed-point output width.
- FRAC_BITS, 32, fractional bits of reciprocal and output (Q(FP_WORD_SIZE-FRAC_BITS).FRAC_BITS).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_stock_id  in  $clog2(NUM_STOCKS)  channel of the incoming quote.
- i_data_valid  in  1  quote valid.
- o_ready  out  1  block can accept a quote this cycle.
- i_best_ask  in  DATA_WIDTH  best ask.
- i_best_bid  in  DATA_WIDTH  best bid.
- i_window_size  in  $clog2(MAX_WINDOW)+1  active window N, 2..MAX_WINDOW.
- i_window_recip  in  FP_WORD_SIZE  1/N in Q.FRAC_BITS.
- i_flush  in  1  clear the state of channel i_stock_id.
- o_volatility  out  FP_WORD_SIZE  windowed variance, Q.FRAC_BITS.
- o_curr_price  out  DATA_WIDTH  mid-price of the processed quote.
- o_stock_id  out  $clog2(NUM_STOCKS)  channel of the result.
- o_window_full  out  1  channel holds N samples.
- o_data_valid  out  1  result strobe (one cycle).
- o_crossed  out  1  one-cycle pulse: quote dropped because ask < bid.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - All outputs go to 0; o_ready goes to 1.
  - FSM goes to IDLE; per-stock count, write pointer, sum and sumsq are cleared.
  - Buffer RAM contents are not cleared (they are don't-care while count=0).
  - Reset mid-operation aborts the in-flight quote; no o_data_valid is produced for it.
- Handshake:
  - A quote is accepted when i_data_valid && o_ready.
  - o_ready=1 only in IDLE. Quotes presented while busy are ignored, not queued.
- FSM: IDLE -> READ -> UPDATE -> MEAN -> VAR -> OUT -> IDLE.
  - Accept at cycle T; o_data_valid=1 at T+5 for one cycle; o_ready returns at T+6 (accepting again at T+6).
- IDLE: register stock id and mid = (ask+bid)>>1, computed at DATA_WIDTH+1 bits then truncated.
  - If ask < bid: pulse o_crossed at T+1, stay in IDLE, leave state unchanged.
- READ: fetch old = buf[stock][wr_ptr].
- UPDATE:
  - If count == N: sum += mid - old; sumsq += mid² - old².
  - Else: sum += mid; sumsq += mid²; count++.
  - Write mid to buf[stock][wr_ptr]; wr_ptr = (wr_ptr == N-1) ? 0 : wr_ptr+1.
- MEAN: mean_q = sum*recip and ex2_q = sumsq*recip, computed at full precision and kept in Q.FRAC_BITS.
- VAR: msq = (mean_q*mean_q)>>FRAC_BITS; var = ex2_q - msq.
  - A negative result clamps to 0.
  - The result truncates to FP_WORD_SIZE (low bits kept).
- OUT:
  - o_volatility = var, o_curr_price = mid, o_stock_id = stock.
  - o_window_full = (count == N), using the post-update count.
- Result during warm-up: while count < N the output is still produced but uses the N reciprocal. Consumers must gate on o_window_full.
- Accumulator widths: sum is DATA_WIDTH+$clog2(MAX_WINDOW)+1; sumsq is 2*DATA_WIDTH+$clog2(MAX_WINDOW)+1. Neither may overflow.
- i_flush: accepted in IDLE only, with i_data_valid=0. Zeroes count, wr_ptr, sum and sumsq of i_stock_id in one cycle. No output is produced.
  - If i_flush and i_data_valid are both high: the flush wins and the quote is dropped.
- i_window_size / i_window_recip:
  - Must be changed only when every channel has count=0 (after reset or after flushing all channels).
  - They are sampled at accept.
  - Behaviour with N outside 2..MAX_WINDOW is undefined.

Decomposition:
- Package volatility_pkg holds:
  - FSM state enum;
  - widths SUM_W and SQ_W;
  - per-stock channel-state struct {count, wr_ptr, sum, sumsq};
  - helper function for the mid-price.
- One sub-module, rolling_volatility_mem: single-port synchronous RAM of NUM_STOCKS*MAX_WINDOW x DATA_WIDTH, addressed {stock, ptr}, with 1-cycle registered read.

Test Plan:
- Reset, then N=4, recip=0x4000_0000, stock 0. Send 4 quotes ask=102, bid=98 -> mid=100 each; o_volatility=0. o_window_full=0,0,0,1; o_data_valid exactly 5 cycles after each accept.
- N=4, stock 1. Mids 100,102,98,100 -> 4th result o_volatility=0x2_0000_0000 (2.0); then mid 104 (wrap, evicts 100) -> 0x5_0000_0000 (5.0), o_window_full=1.
- Interleave stock 0 and stock 2, each with the mid sequence of scenario 2 -> each channel reaches 2.0 then 5.0 independently; o_stock_id matches the input channel.
- Hold i_data_valid high for 10 cycles on one stock -> exactly 2 accepts (cycles 0 and 6); o_ready low on cycles 1-5.
- ask=90, bid=95 -> o_crossed pulse, no o_data_valid. The next valid quote gives the same result as if the crossed quote never arrived.
- Assert i_reset_n=0 at T+3 of a quote -> no o_data_valid. Flush stock 1 mid-stream, then send 4 quotes of mid 100 -> o_window_full only on the 4th, variance 0.
